spi_flash_responder: RTL and testbench

Synthesizable SPI-flash responder: the target-side end of the SPI read protocol issued by the VGA SPI-ROM reader. It samples CS_n/SCLK/MOSI with the system clock, decodes a flash READ command (0x03) plus 24-bit address, fetches bytes from an attached synchronous memory, and shifts them out MSB-first on MISO with auto-incrementing address. It lets the reader run against on-chip or FPGA block RAM instead of the `spiflash` simulation model.

---
 rtl/spi_resp_pkg.sv | 17 +
 rtl/spi_resp_sync.sv | 37 +++
 rtl/spi_flash_responder.sv | 169 ++++++++++++++++
 tb/tb_spi_flash_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI flash responder.
package spi_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam int         ADDR_BITS    = 24;

endpackage

// File: rtl/spi_resp_sync.sv
// Brings CS_n/SCLK/MOSI into the clk domain; SCLK gets a third stage for
// single-cycle rise/fall pulses.
module spi_resp_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_cs_n,
  input  logic i_sclk,
  input  logic i_mosi,
  output logic o_cs_n,
  output logic o_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall
);

  logic [1:0] r_cs_sync;
  logic [1:0] r_mosi_sync;
  logic [2:0] r_sclk_sync;

  // CS_n resets low so a high level must really be seen before arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_sync   <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_sclk_sync <= 3'b000;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], i_cs_n};
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
      r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
    end
  end

  assign o_cs_n      = r_cs_sync[1];
  assign o_mosi      = r_mosi_sync[1];
  assign o_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign o_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash READ (0x03) responder fetching bytes from a 1-cycle-latency memory.
// Optional FAST_READ (0x0B, 8 dummy clocks) under `SPI_RESP_FAST_READ_EN.
//   state  | meaning
//   IDLE   | wait for CS_n low (only after CS_n seen high since reset)
//   CMD    | shift in 8-bit opcode
//   ADDR   | shift in 24-bit address, issue first read
//   DUMMY  | 8 dummy clocks, MISO driven 0 (fast read only)
//   DATA   | shift bytes out on MISO, prefetch next address
//   IGNORE | unsupported opcode, wait for CS_n high
module spi_flash_responder
  import spi_resp_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              busy
);

  logic w_cs_n, w_mosi, w_rise, w_fall;

  spi_resp_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .i_cs_n      (spi_cs_n),
    .i_sclk      (spi_sclk),
    .i_mosi      (spi_mosi),
    .o_cs_n      (w_cs_n),
    .o_mosi      (w_mosi),
    .o_sclk_rise (w_rise),
    .o_sclk_fall (w_fall)
  );

  state_t              r_state;
  logic [4:0]          r_bit_cnt;
  logic [6:0]          r_cmd;
  logic [ADDR_BITS-2:0] r_addr;
  logic [7:0]          r_shift;
  logic                r_rd_d;
  logic                r_skip_fall;
  logic                r_armed;
  logic                r_miso;
  logic                r_oe;
  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
`ifdef SPI_RESP_FAST_READ_EN
  logic                r_fast;
`endif

  logic [7:0]           w_cmd_next;
  logic [ADDR_BITS-1:0] w_addr_next;

  assign w_cmd_next  = {r_cmd, w_mosi};
  assign w_addr_next = {r_addr, w_mosi};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_shift     <= '0;
      r_rd_d      <= 1'b0;
      r_skip_fall <= 1'b0;
      r_armed     <= 1'b0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
`ifdef SPI_RESP_FAST_READ_EN
      r_fast      <= 1'b0;
`endif
    end else begin
      r_mem_rd <= 1'b0;
      r_rd_d   <= r_mem_rd;
      if (w_cs_n) begin
        r_armed     <= 1'b1;
        r_state     <= IDLE;
        r_bit_cnt   <= '0;
        r_oe        <= 1'b0;
        r_miso      <= 1'b0;
        r_skip_fall <= 1'b0;
      end else begin
        r_oe   <= (r_state == DATA) || (r_state == DUMMY);
        r_miso <= (r_state == DATA) & r_shift[7];
        // The fall right after a byte boundary keeps the freshly loaded bit 7.
        if (r_rd_d)
          r_shift <= mem_data;
        else if (w_fall && r_state == DATA) begin
          if (r_skip_fall) r_skip_fall <= 1'b0;
          else             r_shift     <= {r_shift[6:0], 1'b0};
        end
        case (r_state)
          IDLE: begin
            r_bit_cnt <= '0;
            if (r_armed) r_state <= CMD;
          end
          CMD: if (w_rise) begin
            r_cmd     <= w_cmd_next[6:0];
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= '0;
              if (w_cmd_next == OP_READ) begin
                r_state <= ADDR;
`ifdef SPI_RESP_FAST_READ_EN
                r_fast  <= 1'b0;
              end else if (w_cmd_next == OP_FAST_READ) begin
                r_state <= ADDR;
                r_fast  <= 1'b1;
`endif
              end else begin
                r_state <= IGNORE;
              end
            end
          end
          ADDR: if (w_rise) begin
            r_addr    <= w_addr_next[ADDR_BITS-2:0];
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              r_bit_cnt   <= '0;
              r_mem_rd    <= 1'b1;
              r_mem_addr  <= w_addr_next[ADDR_W-1:0];
              r_skip_fall <= 1'b1;
              r_state     <= DATA;
`ifdef SPI_RESP_FAST_READ_EN
              if (r_fast) r_state <= DUMMY;
`endif
            end
          end
`ifdef SPI_RESP_FAST_READ_EN
          DUMMY: if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt   <= '0;
              r_skip_fall <= 1'b1;
              r_state     <= DATA;
            end
          end
`endif
          DATA: if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt   <= '0;
              r_mem_rd    <= 1'b1;
              r_mem_addr  <= r_mem_addr + 1'b1;
              r_skip_fall <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a 24-bit and an 8-bit address instance share
// one SPI bus; expected bytes come from a memory function indexed modulo 2^ADDR_W.
module tb_spi_flash_responder;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset, cs_n, sclk, mosi;
  logic miso24, oe24, rd24, busy24;
  logic [23:0] addr24;
  logic [7:0]  data24;
  logic miso8, oe8, rd8, busy8;
  logic [7:0] addr8;
  logic [7:0] data8;

  int n_checks = 0;
  int n_pass   = 0;
  int rd_cnt   = 0;
  int oe_cnt   = 0;
  logic [23:0] addr_log[$];
  logic [7:0]  rx24 [0:7];
  logic [7:0]  rx8  [0:7];

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_W(24)) dut24 (
    .clk(clk), .reset(reset), .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso24), .spi_miso_oe(oe24), .mem_rd(rd24), .mem_addr(addr24),
    .mem_data(data24), .busy(busy24)
  );

  spi_flash_responder #(.ADDR_W(8)) dut8 (
    .clk(clk), .reset(reset), .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso8), .spi_miso_oe(oe8), .mem_rd(rd8), .mem_addr(addr8),
    .mem_data(data8), .busy(busy8)
  );

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    if (a == 24'h000010) return 8'hA5;
    if (a == 24'h000011) return 8'h3C;
    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Synchronous memories: data valid one clk after the read strobe.
  always @(posedge clk) begin
    if (rd24) begin
      data24 <= mem_val(addr24);
      addr_log.push_back(addr24);
      rd_cnt++;
    end
    if (oe24) oe_cnt++;
    if (rd8) data8 <= mem_val({16'h0000, addr8});
  end

  task automatic spi_bits(input logic [7:0] tx, input int nb,
                          output logic [7:0] r24, output logic [7:0] r8);
    r24 = 8'h00;
    r8  = 8'h00;
    for (int i = 0; i < nb; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      r24 = {r24[6:0], miso24};
      r8  = {r8[6:0], miso8};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r24, output logic [7:0] r8);
    spi_bits(tx, 8, r24, r8);
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_stop();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (4*HALF) @(negedge clk);
  endtask

  task automatic read_body(input logic [7:0] op, input logic [23:0] a, input int n);
    logic [7:0] d24, d8;
    cs_start();
    spi_byte(op, d24, d8);
    spi_byte(a[23:16], d24, d8);
    spi_byte(a[15:8], d24, d8);
    spi_byte(a[7:0], d24, d8);
    for (int i = 0; i < n; i++) spi_byte(8'h00, rx24[i], rx8[i]);
  endtask

  task automatic read_txn(input logic [7:0] op, input logic [23:0] a, input int n);
    read_body(op, a, n);
    cs_stop();
  endtask

  task automatic test_reset();
    reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (miso24 !== 1'b0) $display("FAIL reset_miso: got %b want 0", miso24); else n_pass++;
    n_checks++; if (oe24 !== 1'b0) $display("FAIL reset_oe: got %b want 0", oe24); else n_pass++;
    n_checks++; if (rd24 !== 1'b0) $display("FAIL reset_rd: got %b want 0", rd24); else n_pass++;
    n_checks++; if (addr24 !== 24'h0) $display("FAIL reset_addr: got %h want 0", addr24); else n_pass++;
    n_checks++; if (busy24 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy24); else n_pass++;
    n_checks++; if ({busy8, oe8, rd8, addr8} !== 11'h0) $display("FAIL reset_dut8: got %h want 0", {busy8, oe8, rd8, addr8}); else n_pass++;
    reset = 1'b0;
    repeat (4*HALF) @(negedge clk);
  endtask

  task automatic test_basic_read();
    logic [23:0] want_a;
    addr_log.delete();
    read_body(8'h03, 24'h000010, 2);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (oe24 !== 1'b1) $display("FAIL oe_hold_2clk: got %b want 1", oe24); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (oe24 !== 1'b0) $display("FAIL oe_fall_3clk: got %b want 0", oe24); else n_pass++;
    repeat (4*HALF) @(negedge clk);
    n_checks++; if (rx24[0] !== 8'hA5) $display("FAIL basic_byte0: got %h want a5", rx24[0]); else n_pass++;
    n_checks++; if (rx24[1] !== 8'h3C) $display("FAIL basic_byte1: got %h want 3c", rx24[1]); else n_pass++;
    n_checks++; if (addr_log.size() != 3) $display("FAIL basic_rd_count: got %0d want 3", addr_log.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      want_a = 24'h000010 + 24'(i);
      n_checks++;
      if (i >= addr_log.size()) $display("FAIL basic_addr%0d: got none want %h", i, want_a);
      else if (addr_log[i] !== want_a) $display("FAIL basic_addr%0d: got %h want %h", i, addr_log[i], want_a);
      else n_pass++;
    end
    n_checks++; if (busy24 !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy24); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] a8;
    read_txn(8'h03, 24'h0000FF, 3);
    for (int i = 0; i < 3; i++) begin
      a8 = 8'hFF + 8'(i);
      n_checks++;
      if (rx8[i] !== mem_val({16'h0, a8})) $display("FAIL wrap8_byte%0d: got %h want %h", i, rx8[i], mem_val({16'h0, a8}));
      else n_pass++;
      n_checks++;
      if (rx24[i] !== mem_val(24'h0000FF + 24'(i))) $display("FAIL wrap24_byte%0d: got %h want %h", i, rx24[i], mem_val(24'h0000FF + 24'(i)));
      else n_pass++;
    end
  endtask

  task automatic test_bad_opcode(input logic [7:0] op);
    int rd0, oe0;
    logic [7:0] d24, d8;
    rd0 = rd_cnt; oe0 = oe_cnt;
    cs_start();
    spi_byte(op, d24, d8);
    for (int i = 0; i < 4; i++) spi_byte(8'($urandom()), d24, d8);
    n_checks++; if (busy24 !== 1'b1) $display("FAIL bad_op_busy %h: got %b want 1", op, busy24); else n_pass++;
    cs_stop();
    n_checks++; if (oe_cnt != oe0) $display("FAIL bad_op_oe %h: got %0d oe cycles want 0", op, oe_cnt - oe0); else n_pass++;
    n_checks++; if (rd_cnt != rd0) $display("FAIL bad_op_rd %h: got %0d reads want 0", op, rd_cnt - rd0); else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] d24, d8;
    cs_start();
    spi_byte(8'h03, d24, d8);
    spi_byte(8'h00, d24, d8);
    spi_bits(8'hA8, 5, d24, d8);
    cs_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (busy24 !== 1'b0) $display("FAIL abort_busy24: got %b want 0", busy24); else n_pass++;
    n_checks++; if (busy8 !== 1'b0) $display("FAIL abort_busy8: got %b want 0", busy8); else n_pass++;
    repeat (4*HALF) @(negedge clk);
    read_txn(8'h03, 24'h000020, 1);
    n_checks++; if (rx24[0] !== mem_val(24'h20)) $display("FAIL abort_reread: got %h want %h", rx24[0], mem_val(24'h20)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rd0, oe0;
    logic [7:0] d24, d8;
    read_body(8'h03, 24'h000030, 1);
    spi_bits(8'h00, 3, d24, d8);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_checks++; if (miso24 !== 1'b0) $display("FAIL rstmid_miso: got %b want 0", miso24); else n_pass++;
    n_checks++; if (oe24 !== 1'b0) $display("FAIL rstmid_oe: got %b want 0", oe24); else n_pass++;
    n_checks++; if (rd24 !== 1'b0) $display("FAIL rstmid_rd: got %b want 0", rd24); else n_pass++;
    n_checks++; if (addr24 !== 24'h0) $display("FAIL rstmid_addr: got %h want 0", addr24); else n_pass++;
    n_checks++; if (busy24 !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy24); else n_pass++;
    rd0 = rd_cnt; oe0 = oe_cnt;
    spi_byte(8'h03, d24, d8);
    spi_byte(8'h00, d24, d8);
    spi_byte(8'h00, d24, d8);
    n_checks++; if (busy24 !== 1'b0) $display("FAIL rstmid_stay_idle: got %b want 0", busy24); else n_pass++;
    n_checks++; if (rd_cnt != rd0) $display("FAIL rstmid_no_rd: got %0d reads want 0", rd_cnt - rd0); else n_pass++;
    n_checks++; if (oe_cnt != oe0) $display("FAIL rstmid_no_oe: got %0d oe cycles want 0", oe_cnt - oe0); else n_pass++;
    cs_stop();
    read_txn(8'h03, 24'h000010, 1);
    n_checks++; if (rx24[0] !== 8'hA5) $display("FAIL rstmid_recover: got %h want a5", rx24[0]); else n_pass++;
  endtask

  task automatic test_fast_read();
    int rd0, oe0;
    logic [7:0] d24, d8, q24, q8;
    rd0 = rd_cnt; oe0 = oe_cnt;
    read_body(8'h0B, 24'h000010, 0);
    spi_byte(8'h00, d24, d8);
`ifdef SPI_RESP_FAST_READ_EN
    n_checks++; if (oe24 !== 1'b1) $display("FAIL fast_dummy_oe: got %b want 1", oe24); else n_pass++;
`endif
    spi_byte(8'h00, q24, q8);
    cs_stop();
`ifdef SPI_RESP_FAST_READ_EN
    n_checks++; if (d24 !== 8'h00) $display("FAIL fast_dummy_bits: got %h want 00", d24); else n_pass++;
    n_checks++; if (q24 !== 8'hA5) $display("FAIL fast_data: got %h want a5", q24); else n_pass++;
    n_checks++; if (rd_cnt - rd0 != 2) $display("FAIL fast_rd_count: got %0d want 2", rd_cnt - rd0); else n_pass++;
`else
    n_checks++; if (oe_cnt != oe0) $display("FAIL fast_disabled_oe: got %0d oe cycles want 0", oe_cnt - oe0); else n_pass++;
    n_checks++; if (rd_cnt != rd0) $display("FAIL fast_disabled_rd: got %0d reads want 0", rd_cnt - rd0); else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [23:0] a, ea;
    logic [7:0]  a8, op;
    int n;
    for (int it = 0; it < 6; it++) begin
      a = (it < 2) ? 24'hFFFFFF - 24'(it) : 24'($urandom());
      n = int'($urandom_range(1, 3));
      read_txn(8'h03, a, n);
      for (int i = 0; i < n; i++) begin
        ea = a + 24'(i);
        a8 = a[7:0] + 8'(i);
        n_checks++;
        if (rx24[i] !== mem_val(ea)) $display("FAIL rand%0d_24_b%0d: got %h want %h", it, i, rx24[i], mem_val(ea));
        else n_pass++;
        n_checks++;
        if (rx8[i] !== mem_val({16'h0, a8})) $display("FAIL rand%0d_8_b%0d: got %h want %h", it, i, rx8[i], mem_val({16'h0, a8}));
        else n_pass++;
      end
      op = 8'($urandom());
      if (op == 8'h03 || op == 8'h0B) op = op ^ 8'h80;
      if (it % 3 == 0) test_bad_opcode(op);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_wrap();
    test_bad_opcode(8'h9F);
    read_txn(8'h03, 24'h000011, 1);
    n_checks++; if (rx24[0] !== 8'h3C) $display("FAIL after_bad_read: got %h want 3c", rx24[0]); else n_pass++;
    test_abort();
    test_reset_mid();
    test_fast_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
